// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings, opcodes, ALU selects and opcode decode shared by the multi-cycle control unit.
package ctrl_pkg;
    localparam logic [4:0] S_RESET  = 5'd0;
    localparam logic [4:0] S_FETCH  = 5'd1;
    localparam logic [4:0] S_DECODE = 5'd2;
    localparam logic [4:0] S_ASN    = 5'd3;
    localparam logic [4:0] S_SHIFT  = 5'd4;
    localparam logic [4:0] S_WB     = 5'd5;
    localparam logic [4:0] S_ORI3   = 5'd6;
    localparam logic [4:0] S_ORI4   = 5'd7;
    localparam logic [4:0] S_ORI5   = 5'd8;
    localparam logic [4:0] S_LOAD   = 5'd9;
    localparam logic [4:0] S_LOADWB = 5'd10;
    localparam logic [4:0] S_STORE  = 5'd11;
    localparam logic [4:0] S_BPZ    = 5'd12;
    localparam logic [4:0] S_BZ     = 5'd13;
    localparam logic [4:0] S_BNZ    = 5'd14;
    localparam logic [4:0] S_NOP    = 5'd15;
    localparam logic [4:0] S_STOP   = 5'd16;
    localparam logic [4:0] S_TRAP   = 5'd17;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    localparam logic [2:0] ALU2_ONE   = 3'b001;
    localparam logic [2:0] ALU2_OFFS  = 3'b010;
    localparam logic [2:0] ALU2_IMM   = 3'b011;
    localparam logic [2:0] ALU2_SHAMT = 3'b100;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_NAND  = 3'b011;
    localparam logic [2:0] ALUOP_SHIFT = 3'b100;

    // ALU-class and low-bit patterns take priority over exact opcode matches
    function automatic logic [4:0] decode_op(input logic [3:0] op, input logic trap);
        logic [4:0] s;
        if (op == OP_ADD || op == OP_SUB || op == OP_NAND) s = S_ASN;
        else if (op[2:0] == 3'b011) s = S_SHIFT;
        else if (op[2:0] == 3'b111) s = S_ORI3;
        else begin
            case (op)
                OP_LOAD:  s = S_LOAD;
                OP_STORE: s = S_STORE;
                OP_BPZ:   s = S_BPZ;
                OP_BZ:    s = S_BZ;
                OP_BNZ:   s = S_BNZ;
                OP_NOP:   s = S_NOP;
                OP_STOP:  s = S_STOP;
                default:  s = trap ? S_TRAP : S_RESET;
            endcase
        end
        return s;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset) count_q <= '0;
        else if (inc && count_q != '1) count_q <= count_q + W'(1);
    end

    assign count = count_q;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle datapath sequencer with memory-ready waits, STOP/trap and perf counters.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int CNTW         = 16,
    parameter bit WAIT_EN      = 1'b1,
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      instr,
    input  logic            N,
    input  logic            Z,
    input  logic            mem_ready,
    input  logic            resume,
    output logic            PCwrite,
    output logic            AddrSel,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRload,
    output logic            R1Sel,
    output logic            MDRload,
    output logic            R1R2Load,
    output logic            ALU1,
    output logic            ALUOutWrite,
    output logic            RFWrite,
    output logic            RegIn,
    output logic            FlagWrite,
    output logic            IncCount,
    output logic [2:0]      ALU2,
    output logic [2:0]      ALUop,
    output logic            halted,
    output logic            illegal,
    output logic [4:0]      state_o,
    output logic [CNTW-1:0] cycle_count,
    output logic [CNTW-1:0] instr_count
);
    logic [4:0] state_q, state_d;
    logic       rdy;

    assign rdy = mem_ready | ~WAIT_EN;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: state_d = decode_op(instr, TRAP_ILLEGAL);
            S_ASN, S_SHIFT: state_d = S_WB;
            S_ORI3:   state_d = S_ORI4;
            S_ORI4:   state_d = S_ORI5;
            S_LOAD:   state_d = rdy ? S_LOADWB : S_LOAD;
            S_STORE:  state_d = rdy ? S_FETCH : S_STORE;
            S_WB, S_ORI5, S_LOADWB, S_BPZ, S_BZ, S_BNZ, S_NOP: state_d = S_FETCH;
            S_STOP:   state_d = resume ? S_FETCH : S_STOP;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_RESET;
        else state_q <= state_d;
    end

    assign AddrSel     = state_q == S_FETCH;
    assign MemRead     = state_q == S_FETCH || state_q == S_LOAD;
    assign MemWrite    = state_q == S_STORE;
    assign IRload      = state_q == S_FETCH && rdy;
    assign R1Sel       = state_q == S_ORI3 || state_q == S_ORI5;
    assign MDRload     = state_q == S_LOAD && rdy;
    assign R1R2Load    = state_q == S_DECODE || state_q == S_ORI3;
    assign ALU1        = state_q == S_ASN || state_q == S_SHIFT || state_q == S_ORI4;
    assign ALUOutWrite = ALU1 || state_q == S_LOADWB;
    assign FlagWrite   = ALU1;
    assign RFWrite     = state_q == S_WB || state_q == S_ORI5 || state_q == S_LOADWB;
    assign RegIn       = state_q == S_LOADWB;
    assign IncCount    = !(state_q == S_RESET || state_q == S_STOP || state_q == S_TRAP);
    assign halted      = state_q == S_STOP || state_q == S_TRAP;
    assign illegal     = state_q == S_TRAP;
    assign state_o     = state_q;

    // branches redirect PC from the flags latched by the previous ALU op
    assign PCwrite = (state_q == S_FETCH && rdy) || (state_q == S_BPZ && !N)
                   || (state_q == S_BZ && Z) || (state_q == S_BNZ && !Z);

    assign ALU2 = state_q == S_FETCH ? ALU2_ONE :
                  state_q == S_SHIFT ? ALU2_SHAMT :
                  state_q == S_ORI4  ? ALU2_IMM :
                  (state_q == S_BPZ || state_q == S_BZ || state_q == S_BNZ) ? ALU2_OFFS : 3'b000;

    assign ALUop = state_q == S_ASN   ? (instr == OP_ADD ? ALUOP_ADD : instr == OP_SUB ? ALUOP_SUB : ALUOP_NAND) :
                   state_q == S_SHIFT ? ALUOP_SHIFT :
                   state_q == S_ORI4  ? ALUOP_OR : 3'b000;

    sat_counter #(.W(CNTW)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (IncCount),
        .count (cycle_count)
    );

    sat_counter #(.W(CNTW)) u_instr_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (state_q == S_FETCH && rdy),
        .count (instr_count)
    );
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed sequence over one 16-bit-counter unit and one 4-bit-counter unit.
module tb_multicycle_ctrl_fsm;
    import ctrl_pkg::*;

    logic clock = 1'b0, reset = 1'b0, N = 1'b0, Z = 1'b0, mem_ready = 1'b1, resume = 1'b0;
    logic [3:0] instr = OP_ADD;

    logic a_pcw, a_as, a_mr, a_mw, a_irl, a_r1s, a_mdr, a_rl, a_alu1, a_aow, a_rfw, a_ri, a_fw, a_inc, a_hlt, a_ill;
    logic [2:0] a_alu2, a_aluop;
    logic [4:0] a_state;
    logic [15:0] a_cyc, a_ins;
    logic b_pcw, b_as, b_mr, b_mw, b_irl, b_r1s, b_mdr, b_rl, b_alu1, b_aow, b_rfw, b_ri, b_fw, b_inc, b_hlt, b_ill;
    logic [2:0] b_alu2, b_aluop;
    logic [4:0] b_state;
    logic [3:0] b_cyc, b_ins;
    logic [21:0] a_ctl, b_ctl;

    int tests = 0, fails = 0;

    localparam logic [21:0] CTL_FETCH = {16'b1110_1000_0000_0100, 3'b001, 3'b000};

    assign a_ctl = {a_pcw, a_as, a_mr, a_mw, a_irl, a_r1s, a_mdr, a_rl, a_alu1, a_aow, a_rfw, a_ri, a_fw, a_inc, a_hlt, a_ill, a_alu2, a_aluop};
    assign b_ctl = {b_pcw, b_as, b_mr, b_mw, b_irl, b_r1s, b_mdr, b_rl, b_alu1, b_aow, b_rfw, b_ri, b_fw, b_inc, b_hlt, b_ill, b_alu2, b_aluop};

    always #5 clock = ~clock;

    multicycle_ctrl_fsm #(.CNTW(16)) dut_a (
        .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z), .mem_ready(mem_ready), .resume(resume),
        .PCwrite(a_pcw), .AddrSel(a_as), .MemRead(a_mr), .MemWrite(a_mw), .IRload(a_irl), .R1Sel(a_r1s),
        .MDRload(a_mdr), .R1R2Load(a_rl), .ALU1(a_alu1), .ALUOutWrite(a_aow), .RFWrite(a_rfw), .RegIn(a_ri),
        .FlagWrite(a_fw), .IncCount(a_inc), .ALU2(a_alu2), .ALUop(a_aluop), .halted(a_hlt), .illegal(a_ill),
        .state_o(a_state), .cycle_count(a_cyc), .instr_count(a_ins)
    );

    multicycle_ctrl_fsm #(.CNTW(4)) dut_b (
        .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z), .mem_ready(mem_ready), .resume(resume),
        .PCwrite(b_pcw), .AddrSel(b_as), .MemRead(b_mr), .MemWrite(b_mw), .IRload(b_irl), .R1Sel(b_r1s),
        .MDRload(b_mdr), .R1R2Load(b_rl), .ALU1(b_alu1), .ALUOutWrite(b_aow), .RFWrite(b_rfw), .RegIn(b_ri),
        .FlagWrite(b_fw), .IncCount(b_inc), .ALU2(b_alu2), .ALUop(b_aluop), .halted(b_hlt), .illegal(b_ill),
        .state_o(b_state), .cycle_count(b_cyc), .instr_count(b_ins)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_state", a_state, S_RESET);
        chk("rst_ctl", a_ctl, 0);
        chk("rst_cyc", a_cyc, 0);
        chk("rst_ins", a_ins, 0);
        chk("rst_ctl_b", b_ctl, 0);
        reset = 1'b1;
        // ADD
        step();
        chk("add_fetch_state", a_state, S_FETCH);
        chk("add_fetch_ctl", a_ctl, CTL_FETCH);
        chk("add_fetch_ctl_b", b_ctl, CTL_FETCH);
        chk("add_fetch_cyc", a_cyc, 0);
        step();
        chk("add_decode_state", a_state, S_DECODE);
        chk("add_decode_rl", a_rl, 1);
        step();
        chk("add_asn_state", a_state, S_ASN);
        chk("add_asn_aluop", a_aluop, 3'b000);
        chk("add_asn_fw", a_fw, 1);
        step();
        chk("add_wb_state", a_state, S_WB);
        chk("add_wb_rfw", a_rfw, 1);
        chk("add_wb_ins", a_ins, 1);
        chk("add_wb_cyc", a_cyc, 3);
        step();
        chk("add_end_state", a_state, S_FETCH);
        chk("add_end_cyc", a_cyc, 4);
        // LOAD with three wait cycles
        instr = OP_LOAD;
        step();
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait_state", a_state, S_LOAD);
            chk("ld_wait_mr", a_mr, 1);
            chk("ld_wait_mdr", a_mdr, 0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("ld_rdy_state", a_state, S_LOAD);
        chk("ld_rdy_mdr", a_mdr, 1);
        step();
        chk("ld_wb_state", a_state, S_LOADWB);
        chk("ld_wb_regin", a_ri, 1);
        chk("ld_wb_cyc", a_cyc, 10);
        step();
        chk("ld_end_cyc", a_cyc, 11);
        chk("ld_end_ins", a_ins, 2);
        // BZ not taken, then taken
        instr = OP_BZ;
        step();
        step();
        chk("bz0_state", a_state, S_BZ);
        chk("bz0_pcw", a_pcw, 0);
        chk("bz0_alu2", a_alu2, 3'b010);
        Z = 1'b1;
        #1;
        chk("bz_comb_pcw", a_pcw, 1);
        Z = 1'b0;
        step();
        chk("bz0_end_cyc", a_cyc, 14);
        Z = 1'b1;
        step();
        step();
        chk("bz1_pcw", a_pcw, 1);
        chk("bz1_alu2", a_alu2, 3'b010);
        step();
        Z = 1'b0;
        chk("bz1_end_cyc", a_cyc, 17);
        chk("bz1_end_ins", a_ins, 4);
        // STOP, resume asserted on the entry edge must not skip it
        instr = OP_STOP;
        step();
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("stop_state", a_state, S_STOP);
        chk("stop_halted", a_hlt, 1);
        chk("stop_inc", a_inc, 0);
        chk("stop_cyc", a_cyc, 19);
        for (int i = 0; i < 10; i++) step();
        chk("stop_hold_state", a_state, S_STOP);
        chk("stop_hold_cyc", a_cyc, 19);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("stop_exit_state", a_state, S_FETCH);
        chk("stop_exit_cyc", a_cyc, 19);
        // ORI via 1111
        instr = 4'b1111;
        step();
        step();
        chk("ori3_state", a_state, S_ORI3);
        chk("ori3_r1s", a_r1s, 1);
        chk("ori3_rl", a_rl, 1);
        step();
        chk("ori4_alu2", a_alu2, 3'b011);
        chk("ori4_aluop", a_aluop, 3'b010);
        step();
        chk("ori5_rfw", a_rfw, 1);
        chk("ori5_r1s", a_r1s, 1);
        step();
        chk("ori_end_state", a_state, S_FETCH);
        chk("ori_end_cyc", a_cyc, 24);
        // SHIFT via 0011
        instr = 4'b0011;
        step();
        step();
        chk("shift_state", a_state, S_SHIFT);
        chk("shift_alu2", a_alu2, 3'b100);
        chk("shift_aluop", a_aluop, 3'b100);
        step();
        step();
        chk("shift_end_cyc", a_cyc, 28);
        // illegal 1110 traps until reset
        instr = 4'b1110;
        step();
        step();
        chk("trap_state", a_state, S_TRAP);
        chk("trap_illegal", a_ill, 1);
        chk("trap_halted", a_hlt, 1);
        for (int i = 0; i < 20; i++) step();
        chk("trap_hold_state", a_state, S_TRAP);
        chk("trap_hold_cyc", a_cyc, 30);
        chk("trap_hold_ins", a_ins, 8);
        reset = 1'b0;
        step();
        chk("trap_rst_state", a_state, S_RESET);
        chk("trap_rst_cyc", a_cyc, 0);
        chk("trap_rst_ins", a_ins, 0);
        chk("trap_rst_ctl", a_ctl, 0);
        reset = 1'b1;
        // FETCH wait, then reset during STORE wait
        mem_ready = 1'b0;
        instr = OP_STORE;
        step();
        chk("fwait_pcw", a_pcw, 0);
        chk("fwait_irl", a_irl, 0);
        chk("fwait_mr", a_mr, 1);
        step();
        chk("fwait_state", a_state, S_FETCH);
        chk("fwait_ins", a_ins, 0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        chk("st_state", a_state, S_STORE);
        chk("st_mw", a_mw, 1);
        step();
        chk("st_hold_state", a_state, S_STORE);
        chk("st_hold_mw", a_mw, 1);
        reset = 1'b0;
        step();
        chk("st_rst_state", a_state, S_RESET);
        chk("st_rst_mw", a_mw, 0);
        reset = 1'b1;
        mem_ready = 1'b1;
        // 20 NOPs: 4-bit counters saturate at 15
        instr = OP_NOP;
        step();
        for (int n = 0; n < 20; n++) begin
            step();
            step();
            step();
            if (n == 4) begin
                chk("nop5_cyc_b", b_cyc, 15);
                chk("nop5_ins_b", b_ins, 5);
            end
        end
        chk("nop_state", a_state, S_FETCH);
        chk("nop_cyc_a", a_cyc, 60);
        chk("nop_ins_a", a_ins, 20);
        chk("nop_cyc_b", b_cyc, 15);
        chk("nop_ins_b", b_ins, 15);
        chk("nop_state_b", b_state, S_FETCH);
        chk("nop_ctl_b", b_ctl, CTL_FETCH);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Parametrised next-generation control unit for the multi-cycle processor datapath. It decodes the 4-bit opcode from IR and sequences per-state datapath control signals. It adds three capabilities:
- a memory ready handshake for variable-latency memory;
- resumable STOP and an illegal-opcode trap;
- saturating cycle and instruction performance counters.

Parameters:
CNTW, 16, width of cycle_count and instr_count
WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1
TRAP_ILLEGAL, 1, 1 = undefined opcode enters S_TRAP; 0 = undefined opcode returns to S_RESET

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
instr  in  4  opcode field of IR
N  in  1  negative flag
Z  in  1  zero flag
mem_ready  in  1  memory completes the current access this cycle
resume  in  1  leave S_STOP (level, sampled each cycle)
PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload  out  1 each  datapath controls
R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, IncCount  out  1 each  datapath controls
ALU2  out  3  ALU operand-2 select
ALUop  out  3  ALU operation
halted  out  1  state is S_STOP or S_TRAP
illegal  out  1  state is S_TRAP
state_o  out  5  current state encoding (debug)
cycle_count  out  CNTW  cycles with IncCount=1, saturating
instr_count  out  CNTW  completed fetches, saturating

Behaviour:
- Control outputs are Moore outputs decoded from state; the gated outputs (PCwrite, IRload, MDRload) are also combinational in rdy, N and Z. rdy = mem_ready | ~WAIT_EN.
- reset=0 at a clock edge: next state is S_RESET; counters are cleared. While in S_RESET all outputs are 0. Applies from any state, including mid-wait and S_TRAP.
- Transitions:
  - S_RESET -> S_FETCH.
  - S_FETCH -> S_DECODE when rdy; otherwise hold.
  - S_DECODE dispatches on instr:
    - 0100/0110/1000 -> S_ASN
    - instr[2:0]=011 -> S_SHIFT
    - instr[2:0]=111 -> S_ORI3
    - 0000 -> S_LOAD
    - 0010 -> S_STORE
    - 1101 -> S_BPZ
    - 0101 -> S_BZ
    - 1001 -> S_BNZ
    - 1010 -> S_NOP
    - 0001 -> S_STOP
    - any other opcode -> S_TRAP if TRAP_ILLEGAL, else S_RESET
  - S_ASN, S_SHIFT -> S_WB -> S_FETCH.
  - S_ORI3 -> S_ORI4 -> S_ORI5 -> S_FETCH.
  - S_LOAD -> S_LOADWB when rdy, else hold; S_LOADWB -> S_FETCH.
  - S_STORE -> S_FETCH when rdy, else hold.
  - S_BPZ, S_BZ, S_BNZ, S_NOP -> S_FETCH.
  - S_STOP -> S_FETCH when resume=1, else hold.
  - S_TRAP holds until reset.
- Per-state outputs (all unlisted outputs are 0):
  - FETCH: AddrSel=1, MemRead=1, ALU2=001, PCwrite=rdy, IRload=rdy
  - DECODE: R1R2Load=1
  - ASN: ALU1=1, ALUOutWrite=1, FlagWrite=1; ALUop=000 for add (0100), 001 for sub (0110), 011 for nand
  - SHIFT: ALU1=1, ALU2=100, ALUop=100, ALUOutWrite=1, FlagWrite=1
  - WB: RFWrite=1
  - ORI3: R1Sel=1, R1R2Load=1
  - ORI4: ALU1=1, ALU2=011, ALUop=010, ALUOutWrite=1, FlagWrite=1
  - ORI5: R1Sel=1, RFWrite=1
  - LOAD: MemRead=1, MDRload=rdy
  - LOADWB: ALUOutWrite=1, RFWrite=1, RegIn=1
  - STORE: MemWrite=1, held for the whole wait
  - BPZ: ALU2=010, PCwrite=~N
  - BZ: ALU2=010, PCwrite=Z
  - BNZ: ALU2=010, PCwrite=~Z
- IncCount=1 in every state except S_RESET, S_STOP and S_TRAP.
- Latency with rdy=1 (cycles from S_FETCH back to S_FETCH):
  - 3: store, branch, nop
  - 4: add/sub/nand, shift, load
  - 5: ori
  - Each wait cycle adds one cycle.
- Counters: cycle_count +1 on each clock edge where IncCount=1. instr_count +1 on each S_FETCH cycle with rdy=1. Both saturate at 2^CNTW-1 and never wrap.
- Simultaneous events:
  - resume=1 on the entry edge to S_STOP is ignored; STOP always lasts at least 1 cycle.
  - reset has priority over rdy and resume.

Decomposition:
- Package ctrl_pkg holds:
  - state localparams (5-bit);
  - opcode constants (OP_ADD=4'b0100, and so on);
  - ALU2/ALUop encodings.
- One sub-module, sat_counter (parameter W; inputs clock, reset, inc; output count), instantiated twice for the two performance counters.

Test Plan:
- ADD with mem_ready=1 -> states RESET, FETCH, DECODE, ASN, WB, FETCH; ALUop=000 and FlagWrite=1 in ASN; RFWrite=1 in WB; instr_count=1 when WB is reached.
- LOAD with mem_ready low for 3 cycles in S_LOAD -> MemRead=1 and MDRload=0 for those 3 cycles, MDRload=1 on the 4th cycle, then S_LOADWB with RegIn=1; cycle_count increases by 3 + the base count.
- BZ with Z=0, then BZ with Z=1 -> PCwrite=0, then PCwrite=1, ALU2=010 in both.
- STOP (0001) with resume=0 for 10 cycles -> halted=1, IncCount=0, cycle_count frozen; resume=1 -> S_FETCH on the next edge.
- Opcode 1111 with TRAP_ILLEGAL=1 -> S_ORI3 (instr[2:0]=111 decodes as ORI, not trap). Opcode 0011 -> shift. Opcode 1110 -> S_TRAP, illegal=1, held 20 cycles; reset=0 for 1 cycle -> S_RESET, counters 0.
- CNTW=4: run 20 NOPs -> cycle_count and instr_count stick at 15, no wrap. reset=0 asserted during an S_STORE wait -> MemWrite=0 on the next cycle.
